// File: rtl/spi_master.sv
// SPI master with a 4-register CPU port (DATA, CTRL, STATUS, SS).
// Ports: clk, reset (sync, active-high), addr/din/dout/wr_en/rd_en CPU bus,
//        sclk/mosi/miso SPI lines, ss_n[NUM_SS] selects,
//        irq only when SPI_MASTER_IRQ_EN is defined.
module spi_master #(
  parameter int NUM_SS = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        addr,
  input  logic [7:0]        din,
  output logic [7:0]        dout,
  input  logic              wr_en,
  input  logic              rd_en,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_SS-1:0] ss_n
`ifdef SPI_MASTER_IRQ_EN
  ,
  output logic              irq
`endif
);

`ifdef SPI_MASTER_IRQ_EN
  localparam logic [5:0] CTRL_MASK = 6'h3F;
`else
  localparam logic [5:0] CTRL_MASK = 6'h1F;
`endif

  typedef enum logic {
    S_IDLE,
    S_XFER
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [5:0] r_ctrl;
  logic [7:0] r_ss;
  logic [7:0] r_tx;
  logic [7:0] r_rx;
  logic [7:0] r_rx_data;
  logic [2:0] r_div_cnt;
  logic [3:0] r_half;
  logic       r_done;
  logic       r_mosi;

  logic       w_busy;
  logic       w_cpol;
  logic       w_cpha;
  logic [2:0] w_div;
  logic       w_sel_data;
  logic       w_sel_ctrl;
  logic       w_sel_ss;
  logic       w_start;
  logic       w_tick;
  logic       w_last;
  logic       w_lead;
  logic       w_trail;
  logic       w_sample;
  logic       w_shift;
  logic [7:0] w_rx_next;
  logic       w_unused;

  assign w_cpol     = r_ctrl[0];
  assign w_cpha     = r_ctrl[1];
  assign w_div      = r_ctrl[4:2];
  assign w_sel_data = (addr[1:0] == 2'd0);
  assign w_sel_ctrl = (addr[1:0] == 2'd1);
  assign w_sel_ss   = (addr[1:0] == 2'd3);
  assign w_unused   = ^addr[7:2];

  assign w_start = wr_en & w_sel_data & ~w_busy;

  // A tick ends a half-period; sclk toggles on every tick. Even
  // half-periods end in a leading edge, odd ones in a trailing edge.
  assign w_tick  = w_busy & (r_div_cnt == w_div);
  assign w_last  = w_tick & (r_half == 4'd15);
  assign w_lead  = w_tick & ~r_half[0];
  assign w_trail = w_tick & r_half[0];

  // CPHA=0 already presented bit7 at start, so its final trailing
  // edge must not shift: mosi keeps the last bit while idle.
  assign w_sample  = w_cpha ? w_trail : w_lead;
  assign w_shift   = w_cpha ? w_lead : (w_trail & ~w_last);
  assign w_rx_next = {r_rx[6:0], miso};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_start) w_next = S_XFER;
      S_XFER: if (w_last) w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy = (r_state == S_XFER);
    sclk   = w_cpol ^ (w_busy & r_half[0]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ctrl    <= '0;
      r_ss      <= '0;
      r_tx      <= '0;
      r_rx      <= '0;
      r_rx_data <= '0;
      r_div_cnt <= '0;
      r_half    <= '0;
      r_done    <= 1'b0;
      r_mosi    <= 1'b0;
    end else begin
      if (wr_en && w_sel_ss) begin
        r_ss <= din;
      end
      if (wr_en && w_sel_ctrl && !w_busy) begin
        r_ctrl <= din[5:0] & CTRL_MASK;
      end
      if (w_start) begin
        r_tx      <= w_cpha ? din : {din[6:0], 1'b0};
        r_rx      <= '0;
        r_div_cnt <= '0;
        r_half    <= '0;
        if (!w_cpha) begin
          r_mosi <= din[7];
        end
      end else if (w_busy) begin
        if (w_tick) begin
          r_div_cnt <= '0;
          r_half    <= r_half + 4'd1;
        end else begin
          r_div_cnt <= r_div_cnt + 3'd1;
        end
        if (w_sample) begin
          r_rx <= w_rx_next;
        end
        if (w_shift) begin
          r_mosi <= r_tx[7];
          r_tx   <= {r_tx[6:0], 1'b0};
        end
      end
      // CPHA=1 takes its last sample on the final edge itself.
      if (w_last) begin
        r_rx_data <= w_sample ? w_rx_next : r_rx;
        r_done    <= 1'b1;
      end else if (rd_en && w_sel_data) begin
        r_done <= 1'b0;
      end
    end
  end

  always_comb begin
    dout = '0;
    unique case (addr[1:0])
      2'd0: dout = r_rx_data;
      2'd1: dout = {2'b00, r_ctrl};
      2'd2: dout = {6'd0, r_done, w_busy};
      2'd3: dout = r_ss;
    endcase
  end

  assign mosi = r_mosi;
  assign ss_n = ~r_ss[NUM_SS-1:0];

`ifdef SPI_MASTER_IRQ_EN
  assign irq = r_done & r_ctrl[5];
`endif

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: random transfers against a behavioural SPI
// slave and a queue of expected results checked on each DATA read.
module tb_spi_master;

  localparam int NSS = 3;
`ifdef SPI_MASTER_IRQ_EN
  localparam logic [7:0] CMASK = 8'h3F;
`else
  localparam logic [7:0] CMASK = 8'h1F;
`endif

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [7:0]     addr = '0;
  logic [7:0]     din = '0;
  logic [7:0]     dout;
  logic           wr_en = 1'b0;
  logic           rd_en = 1'b0;
  logic           sclk;
  logic           mosi;
  logic           miso = 1'b0;
  logic [NSS-1:0] ss_n;
`ifdef SPI_MASTER_IRQ_EN
  logic           irq;
`endif

  always #5 clk = ~clk;

  spi_master #(.NUM_SS(NSS)) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .din   (din),
    .dout  (dout),
    .wr_en (wr_en),
    .rd_en (rd_en),
    .sclk  (sclk),
    .mosi  (mosi),
    .miso  (miso),
    .ss_n  (ss_n)
`ifdef SPI_MASTER_IRQ_EN
    ,
    .irq   (irq)
`endif
  );

  typedef struct {
    logic [7:0] tx;
    logic [7:0] rx;
    logic       cpol;
    logic [2:0] div;
    logic [7:0] ss;
    logic       ie;
  } exp_t;

  exp_t sb[$];
  int   nvec = 0;
  int   nerr = 0;
  bit   mon_en = 1'b1;
  int   meas_len = 0;

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
    end
  endtask

  // Behavioural slave: mode-aware, bit counts by observed edges.
  int         arm_id = 0;
  int         s_seen = 0;
  logic [7:0] s_byte = '0;
  logic       s_cpol = 1'b0;
  logic       s_cpha = 1'b0;
  int         s_nlead = 0;
  int         s_ntrail = 0;
  logic [7:0] s_cap = '0;
  logic       s_prev = 1'b0;

  always @(negedge clk) begin
    if (arm_id != s_seen) begin
      s_seen   = arm_id;
      s_nlead  = 0;
      s_ntrail = 0;
      s_cap    = '0;
      miso     = s_byte[7];
    end else if (sclk !== s_prev) begin
      if (sclk == ~s_cpol) begin
        if (s_cpha) begin
          if (s_nlead < 8) miso = s_byte[7-s_nlead];
        end else begin
          s_cap = {s_cap[6:0], mosi};
        end
        s_nlead++;
      end else begin
        if (s_cpha) begin
          s_cap = {s_cap[6:0], mosi};
        end else if (s_ntrail < 7) begin
          miso = s_byte[6-s_ntrail];
        end
        s_ntrail++;
      end
    end
    s_prev = sclk;
  end

  // Monitor: every DATA read strobe is a result the CPU consumes.
  exp_t           me;
  logic [NSS-1:0] m_ssn;
  always @(negedge clk) begin
    #2;
    if (mon_en && rd_en && addr == 8'd0) begin
      if (sb.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL extra_done: got a result, expected none queued");
      end else begin
        me    = sb.pop_front();
        m_ssn = ~me.ss[NSS-1:0];
        check("rx_byte", dout, me.rx);
        check("mosi_byte", s_cap, me.tx);
        check("lead_edges", s_nlead, 8);
        check("trail_edges", s_ntrail, 8);
        check("busy_len", meas_len, 16 * (int'(me.div) + 1));
        check("sclk_end", sclk, me.cpol);
        check("mosi_hold", mosi, me.tx[0]);
        check("ss_n", ss_n, m_ssn);
`ifdef SPI_MASTER_IRQ_EN
        check("irq", irq, me.ie);
`endif
      end
    end
  end

  task automatic bus_wr(input logic [7:0] a, input logic [7:0] d);
    addr  = a;
    din   = d;
    wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic run_xfer(input logic [7:0] ctrl, input logic [7:0] ss,
                          input logic [7:0] tx, input logic [7:0] sbyte,
                          input bit junk);
    exp_t       e;
    logic [7:0] st;
    int         blen;
    bus_wr(8'd1, ctrl);
    bus_wr(8'd3, ss);
    addr = 8'd1;
    #1;
    check("ctrl_rd", dout, ctrl & CMASK);
    check("sclk_idle", sclk, ctrl[0]);
    s_byte = sbyte;
    s_cpol = ctrl[0];
    s_cpha = ctrl[1];
    arm_id++;
    e.tx   = tx;
    e.rx   = sbyte;
    e.cpol = ctrl[0];
    e.div  = ctrl[4:2];
    e.ss   = ss;
    e.ie   = ctrl[5] & CMASK[5];
    sb.push_back(e);
    @(negedge clk);
    addr  = 8'd0;
    din   = tx;
    wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    blen  = 0;
    st    = '0;
    forever begin
      addr = 8'd2;
      #1;
      st = dout;
      if (!st[0]) break;
      blen++;
      if (blen > 300) begin
        nvec++;
        nerr++;
        $display("FAIL busy_timeout: got BUSY after %0d, expected <=128",
                 blen);
        break;
      end
      if (junk && blen == 3) begin
        addr  = 8'd0;
        din   = 8'hFF;
        wr_en = 1'b1;
        @(negedge clk);
        addr = 8'd1;
        din  = 8'($urandom);
        @(negedge clk);
        addr = 8'd3;
        din  = ss ^ 8'h07;
        @(negedge clk);
        wr_en = 1'b0;
        sb[sb.size()-1].ss = ss ^ 8'h07;
        blen += 2;
      end else begin
        @(negedge clk);
      end
    end
    meas_len = blen;
    check("done_set", st[1], 1'b1);
    addr  = 8'd0;
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    addr  = 8'd2;
    #1;
    check("done_clr", dout[1], 1'b0);
`ifdef SPI_MASTER_IRQ_EN
    check("irq_clr", irq, 1'b0);
`endif
  endtask

  initial begin
    logic [7:0] c;
    logic [7:0] t;
    logic [7:0] s;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int a = 0; a < 4; a++) begin
      addr = 8'(a);
      #1;
      check("reset_reg", dout, 8'h00);
    end
    check("reset_sclk", sclk, 1'b0);
    check("reset_mosi", mosi, 1'b0);
    check("reset_ss_n", ss_n, 3'b111);

    run_xfer(8'h00, 8'h01, 8'hA5, 8'h3C, 1'b0);
    run_xfer(8'h1F, 8'h01, 8'h81, 8'h81, 1'b0);
    run_xfer(8'h00, 8'h02, 8'h55, 8'h96, 1'b1);

    for (int i = 0; i < 20; i++) begin
      c = 8'($urandom);
      t = 8'($urandom);
      s = ($urandom_range(0, 3) == 0) ? t : 8'($urandom);
      run_xfer(c, 8'($urandom), t, s, ($urandom_range(0, 3) == 0));
    end

    // DONE set and DATA read on the same edge: set wins.
    mon_en = 1'b0;
    bus_wr(8'd1, 8'h00);
    addr  = 8'd0;
    din   = 8'h5A;
    wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    addr  = 8'd2;
    #1;
    check("busy_rise", dout[0], 1'b1);
    repeat (15) @(negedge clk);
    addr = 8'd2;
    #1;
    check("busy_last", dout[0], 1'b1);
    addr  = 8'd0;
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    addr  = 8'd2;
    #1;
    check("done_wins", dout[1:0], 2'b10);
    addr  = 8'd0;
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    addr  = 8'd2;
    #1;
    check("done_clr2", dout[1], 1'b0);

    // Reset during half-period 7 aborts the transfer.
    bus_wr(8'd1, 8'h04);
    bus_wr(8'd3, 8'h05);
    addr  = 8'd0;
    din   = 8'hC3;
    wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    repeat (14) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_ss_n", ss_n, 3'b111);
    check("abort_sclk", sclk, 1'b0);
    check("abort_mosi", mosi, 1'b0);
    addr = 8'd2;
    #1;
    check("abort_status", dout, 8'h00);
    addr = 8'd0;
    #1;
    check("abort_rx", dout, 8'h00);
    addr = 8'd1;
    #1;
    check("abort_ctrl", dout, 8'h00);

    check("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
